// File: rtl/control_sequencer.sv
// Microstep sequencer for an 8-bit bus machine: counts T0..T4 and decodes the
// active-low control word from the current step and the IR opcode nibble.
module control_sequencer #(
    parameter bit EARLY_END = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] ir_opcode,
    output logic [2:0] step,
    output logic       halted,
    output logic       pc_count,
    output logic       pc_load_n,
    output logic       pc_bus_enable_n,
    output logic       ram_load_mar_reg_n,
    output logic       ram_bus_enable_n,
    output logic       ram_write_enable_n,
    output logic       ir_load_n,
    output logic       ir_bus_enable_n,
    output logic       reg_a_load_n,
    output logic       reg_a_bus_enable_n,
    output logic       reg_b_load_n,
    output logic       alu_enable_n,
    output logic       alu_subtract,
    output logic       out_load_n
);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4} step_t;

    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    step_t step_q;

    // Last microstep that does useful work for each opcode; fetch-only opcodes end at T1.
    function automatic step_t last_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA:         last_step = T3;
            OP_ADD, OP_SUB:         last_step = T4;
            OP_LDI, OP_JMP, OP_OUT,
            OP_HLT:                 last_step = T2;
            default:                last_step = T1;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q <= T0;
            halted <= 1'b0;
        end else if (run && !halted) begin
            if (step_q == T2 && ir_opcode == OP_HLT) begin
                halted <= 1'b1;
            end else if (step_q == T4 || (EARLY_END && step_q == last_step(ir_opcode))) begin
                step_q <= T0;
            end else begin
                step_q <= step_t'(3'(step_q + 3'd1));
            end
        end
    end

    assign step = step_q;

    // Reset is folded into the gate so the control word drops the instant reset rises.
    always_comb begin
        pc_count           = 1'b0;
        pc_load_n          = 1'b1;
        pc_bus_enable_n    = 1'b1;
        ram_load_mar_reg_n = 1'b1;
        ram_bus_enable_n   = 1'b1;
        ram_write_enable_n = 1'b1;
        ir_load_n          = 1'b1;
        ir_bus_enable_n    = 1'b1;
        reg_a_load_n       = 1'b1;
        reg_a_bus_enable_n = 1'b1;
        reg_b_load_n       = 1'b1;
        alu_enable_n       = 1'b1;
        alu_subtract       = 1'b0;
        out_load_n         = 1'b1;
        if (!reset && run && !halted) begin
            case (step_q)
                T0: begin
                    pc_bus_enable_n    = 1'b0;
                    ram_load_mar_reg_n = 1'b0;
                end
                T1: begin
                    ram_bus_enable_n = 1'b0;
                    ir_load_n        = 1'b0;
                    pc_count         = 1'b1;
                end
                T2: begin
                    case (ir_opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_bus_enable_n    = 1'b0;
                            ram_load_mar_reg_n = 1'b0;
                        end
                        OP_LDI: begin
                            ir_bus_enable_n = 1'b0;
                            reg_a_load_n    = 1'b0;
                        end
                        OP_JMP: begin
                            ir_bus_enable_n = 1'b0;
                            pc_load_n       = 1'b0;
                        end
                        OP_OUT: begin
                            reg_a_bus_enable_n = 1'b0;
                            out_load_n         = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (ir_opcode)
                        OP_LDA: begin
                            ram_bus_enable_n = 1'b0;
                            reg_a_load_n     = 1'b0;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_bus_enable_n = 1'b0;
                            reg_b_load_n     = 1'b0;
                        end
                        OP_STA: begin
                            reg_a_bus_enable_n = 1'b0;
                            ram_write_enable_n = 1'b0;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (ir_opcode == OP_ADD || ir_opcode == OP_SUB) begin
                        alu_enable_n = 1'b0;
                        reg_a_load_n = 1'b0;
                        alu_subtract = (ir_opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: one instance per EARLY_END setting, shared stimulus.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b1;
    logic [3:0] ir_opcode = 4'b0001;

    logic [2:0] step0, step1;
    logic       halted0, halted1;
    logic pc_count0, pc_load_n0, pc_bus_enable_n0, ram_load_mar_reg_n0, ram_bus_enable_n0;
    logic ram_write_enable_n0, ir_load_n0, ir_bus_enable_n0, reg_a_load_n0, reg_a_bus_enable_n0;
    logic reg_b_load_n0, alu_enable_n0, alu_subtract0, out_load_n0;
    logic pc_count1, pc_load_n1, pc_bus_enable_n1, ram_load_mar_reg_n1, ram_bus_enable_n1;
    logic ram_write_enable_n1, ir_load_n1, ir_bus_enable_n1, reg_a_load_n1, reg_a_bus_enable_n1;
    logic reg_b_load_n1, alu_enable_n1, alu_subtract1, out_load_n1;

    always #5 clk = ~clk;

    control_sequencer #(.EARLY_END(1'b0)) dut_full (
        .clk(clk), .reset(reset), .run(run), .ir_opcode(ir_opcode),
        .step(step0), .halted(halted0),
        .pc_count(pc_count0), .pc_load_n(pc_load_n0), .pc_bus_enable_n(pc_bus_enable_n0),
        .ram_load_mar_reg_n(ram_load_mar_reg_n0), .ram_bus_enable_n(ram_bus_enable_n0),
        .ram_write_enable_n(ram_write_enable_n0), .ir_load_n(ir_load_n0),
        .ir_bus_enable_n(ir_bus_enable_n0), .reg_a_load_n(reg_a_load_n0),
        .reg_a_bus_enable_n(reg_a_bus_enable_n0), .reg_b_load_n(reg_b_load_n0),
        .alu_enable_n(alu_enable_n0), .alu_subtract(alu_subtract0), .out_load_n(out_load_n0)
    );

    control_sequencer #(.EARLY_END(1'b1)) dut_early (
        .clk(clk), .reset(reset), .run(run), .ir_opcode(ir_opcode),
        .step(step1), .halted(halted1),
        .pc_count(pc_count1), .pc_load_n(pc_load_n1), .pc_bus_enable_n(pc_bus_enable_n1),
        .ram_load_mar_reg_n(ram_load_mar_reg_n1), .ram_bus_enable_n(ram_bus_enable_n1),
        .ram_write_enable_n(ram_write_enable_n1), .ir_load_n(ir_load_n1),
        .ir_bus_enable_n(ir_bus_enable_n1), .reg_a_load_n(reg_a_load_n1),
        .reg_a_bus_enable_n(reg_a_bus_enable_n1), .reg_b_load_n(reg_b_load_n1),
        .alu_enable_n(alu_enable_n1), .alu_subtract(alu_subtract1), .out_load_n(out_load_n1)
    );

    // Control word, MSB first: pc_count .. out_load_n
    localparam int B_PCCNT = 13, B_PCLD = 12, B_PCBUS = 11, B_MAR = 10, B_RAMBUS = 9;
    localparam int B_RAMWE = 8, B_IRLD = 7, B_IRBUS = 6, B_ALD = 5, B_ABUS = 4;
    localparam int B_BLD = 3, B_ALUEN = 2, B_SUB = 1, B_OUTLD = 0;
    localparam logic [13:0] INACT = 14'b01111111111101;

    logic [13:0] ctl0, ctl1;
    assign ctl0 = {pc_count0, pc_load_n0, pc_bus_enable_n0, ram_load_mar_reg_n0, ram_bus_enable_n0,
                   ram_write_enable_n0, ir_load_n0, ir_bus_enable_n0, reg_a_load_n0,
                   reg_a_bus_enable_n0, reg_b_load_n0, alu_enable_n0, alu_subtract0, out_load_n0};
    assign ctl1 = {pc_count1, pc_load_n1, pc_bus_enable_n1, ram_load_mar_reg_n1, ram_bus_enable_n1,
                   ram_write_enable_n1, ir_load_n1, ir_bus_enable_n1, reg_a_load_n1,
                   reg_a_bus_enable_n1, reg_b_load_n1, alu_enable_n1, alu_subtract1, out_load_n1};

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word straight from the microcode table.
    function automatic logic [13:0] exp_ctl(input int s, input logic [3:0] op);
        logic [13:0] c;
        c = INACT;
        case (s)
            0: begin c[B_PCBUS] = 1'b0; c[B_MAR] = 1'b0; end
            1: begin c[B_RAMBUS] = 1'b0; c[B_IRLD] = 1'b0; c[B_PCCNT] = 1'b1; end
            2: case (op)
                4'd1, 4'd2, 4'd3, 4'd4: begin c[B_IRBUS] = 1'b0; c[B_MAR] = 1'b0; end
                4'd5:  begin c[B_IRBUS] = 1'b0; c[B_ALD] = 1'b0; end
                4'd6:  begin c[B_IRBUS] = 1'b0; c[B_PCLD] = 1'b0; end
                4'd14: begin c[B_ABUS] = 1'b0; c[B_OUTLD] = 1'b0; end
                default: ;
            endcase
            3: case (op)
                4'd1:       begin c[B_RAMBUS] = 1'b0; c[B_ALD] = 1'b0; end
                4'd2, 4'd3: begin c[B_RAMBUS] = 1'b0; c[B_BLD] = 1'b0; end
                4'd4:       begin c[B_ABUS] = 1'b0; c[B_RAMWE] = 1'b0; end
                default: ;
            endcase
            4: if (op == 4'd2 || op == 4'd3) begin
                c[B_ALUEN] = 1'b0; c[B_ALD] = 1'b0; c[B_SUB] = (op == 4'd3);
            end
            default: ;
        endcase
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        check({tag, "_rst_step"}, 32'(step0), 32'd0);
        check({tag, "_rst_halt"}, 32'(halted0), 32'd0);
        check({tag, "_rst_ctl"}, 32'(ctl0), 32'(INACT));
        check({tag, "_rst_ctl_e"}, 32'(ctl1), 32'(INACT));
        reset = 1'b0;
        #1;
    endtask

    logic [2:0] lat_early [16] = '{3'd2, 3'd4, 3'd5, 3'd5, 3'd4, 3'd3, 3'd3, 3'd2,
                                    3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd0};

    initial begin
        // LDA through all five steps with the full-length sequencer
        ir_opcode = 4'b0001;
        run = 1'b1;
        do_reset("lda");
        check("lda_t0_ctl", 32'(ctl0), 32'(exp_ctl(0, 4'd1)));
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("lda_step%0d", k), 32'(step0), 32'(k % 5));
            check($sformatf("lda_ctl%0d", k), 32'(ctl0), 32'(exp_ctl(k % 5, 4'd1)));
        end

        // SUB: subtract only during T4
        ir_opcode = 4'b0011;
        do_reset("sub");
        for (int k = 0; k < 5; k++) begin
            check($sformatf("sub_alusub_t%0d", k), 32'(alu_subtract0), 32'(k == 4));
            check($sformatf("sub_ctl_t%0d", k), 32'(ctl0), 32'(exp_ctl(k, 4'd3)));
            tick();
        end

        // HLT: halts on the edge ending T2 and ignores run afterwards
        ir_opcode = 4'b1111;
        do_reset("hlt");
        tick();
        tick();
        check("hlt_t2_step", 32'(step0), 32'd2);
        check("hlt_t2_halt", 32'(halted0), 32'd0);
        check("hlt_t2_ctl", 32'(ctl0), 32'(INACT));
        tick();
        check("hlt_halted", 32'(halted0), 32'd1);
        check("hlt_halted_e", 32'(halted1), 32'd1);
        for (int k = 0; k < 10; k++) begin
            run = k[0];
            tick();
            check("hlt_hold_step", 32'(step0), 32'd2);
            check("hlt_hold_ctl", 32'(ctl0), 32'(INACT));
        end
        run = 1'b1;
        ir_opcode = 4'b0000;
        do_reset("hlt_clr");
        check("hlt_cleared", 32'(halted0), 32'd0);

        // Pause during T1
        ir_opcode = 4'b0001;
        do_reset("pause");
        tick();
        run = 1'b0;
        #1;
        check("pause_pccnt_0", 32'(pc_count0), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("pause_step", 32'(step0), 32'd1);
            check("pause_pccnt", 32'(pc_count0), 32'd0);
            check("pause_ctl", 32'(ctl0), 32'(INACT));
        end
        run = 1'b1;
        #1;
        check("resume_pccnt", 32'(pc_count0), 32'd1);
        tick();
        check("resume_step", 32'(step0), 32'd2);
        check("resume_pccnt_off", 32'(pc_count0), 32'd0);

        // Asynchronous reset in the middle of STA T3
        ir_opcode = 4'b0100;
        do_reset("sta");
        tick();
        tick();
        tick();
        check("sta_t3_we", 32'(ram_write_enable_n0), 32'd0);
        #2;
        reset = 1'b1;
        #1;
        check("sta_arst_we", 32'(ram_write_enable_n0), 32'd1);
        check("sta_arst_step", 32'(step0), 32'd0);
        check("sta_arst_ctl", 32'(ctl0), 32'(INACT));

        // Instruction latency for both sequencer variants
        for (int op = 0; op < 15; op++) begin
            int n0, n1;
            ir_opcode = 4'(op);
            do_reset("lat");
            n0 = 0;
            n1 = 0;
            for (int k = 1; k <= 6; k++) begin
                tick();
                if (n0 == 0 && step0 == 3'd0) n0 = k;
                if (n1 == 0 && step1 == 3'd0) n1 = k;
            end
            check($sformatf("lat_full_op%0d", op), 32'(n0), 32'd5);
            check($sformatf("lat_early_op%0d", op), 32'(n1), 32'(lat_early[op]));
        end

        // Sweep every opcode through every reachable step
        for (int op = 0; op < 16; op++) begin
            int es;
            logic hexp;
            ir_opcode = 4'(op);
            do_reset("sweep");
            es = 0;
            hexp = 1'b0;
            for (int k = 0; k < 6; k++) begin
                int drivers;
                drivers = 5 - $countones({pc_bus_enable_n0, ram_bus_enable_n0, ir_bus_enable_n0,
                                          reg_a_bus_enable_n0, alu_enable_n0});
                check($sformatf("sw_step_op%0d", op), 32'(step0), 32'(es));
                check($sformatf("sw_ctl_op%0d_t%0d", op, es), 32'(ctl0),
                      32'(hexp ? INACT : exp_ctl(es, 4'(op))));
                check($sformatf("sw_onedrv_op%0d_t%0d", op, es), 32'(drivers <= 1), 32'd1);
                tick();
                if (op == 15 && es == 2) hexp = 1'b1;
                else if (!hexp) es = (es + 1) % 5;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
